// File: rtl/gf16_reduce_acc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gf16_reduce_acc_pkg
//  Brief    : Shared GF(2^16) constants and the stage-1 term record.
//  Revision : 1.0 - initial release
// ============================================================================
package gf16_reduce_acc_pkg;

    // Field element width and width of an unreduced 16x16 carry-less product
    localparam int FIELD_W = 16;
    localparam int PROD_W  = 31;

    // Low coefficients of x^16 + x^5 + x^3 + x^2 + 1 (x^16 term implicit)
    localparam logic [FIELD_W-1:0] POLY_DEFAULT = 16'h002D;

    // One accepted term together with its framing flags
    typedef struct packed {
        logic [PROD_W-1:0] prod;
        logic              first;
        logic              last;
    } term_t;

endpackage
`default_nettype wire

// File: rtl/gf16_reduce_acc_reduce.sv
`default_nettype none
// ============================================================================
//  Module   : gf16_reduce
//  Brief    : Combinational reduction of a 31-bit GF(2)[x] product modulo
//             x^16 + poly. Pure logic, shared by the field datapath stages.
//  Revision : 1.0 - initial release
// ============================================================================
module gf16_reduce
    import gf16_reduce_acc_pkg::*;
(
    input  logic [PROD_W-1:0]  prod,
    input  logic [FIELD_W-1:0] poly,
    output logic [FIELD_W-1:0] r
);

    // Full modulus with the implicit x^16 term made explicit, zero-extended
    logic [PROD_W-1:0] modulus;
    logic [PROD_W-1:0] work;

    // Long division from the top coefficient down: each set bit at or above
    // x^16 is cancelled by XOR-ing in the modulus aligned to that position.
    always_comb begin
        modulus = {{(PROD_W-FIELD_W-1){1'b0}}, 1'b1, poly};
        work    = prod;
        for (int i = PROD_W - 1; i >= FIELD_W; i--) begin
            if (work[i]) begin
                work = work ^ (modulus << (i - FIELD_W));
            end
        end
        r = work[FIELD_W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/gf16_reduce_acc.sv
`default_nettype none
// ============================================================================
//  Module   : gf16_reduce_acc
//  Brief    : Two-stage GF(2^16) reduce-and-accumulate. Stage 1 registers an
//             unreduced product term; stage 2 reduces it and XOR-accumulates
//             it into the frame sum, publishing the sum on the last term.
//  Revision : 1.0 - initial release
// ============================================================================
module gf16_reduce_acc
    import gf16_reduce_acc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PROD_W-1:0]  in_prod,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [FIELD_W-1:0] poly_i,
    input  logic               poly_ld,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIELD_W-1:0] out_data,
    output logic               busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    term_t              s1_q,        s1_d;
    logic               s1_valid_q,  s1_valid_d;
    logic [FIELD_W-1:0] acc_q,       acc_d;
    logic               mid_frame_q, mid_frame_d;
    logic [FIELD_W-1:0] out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [FIELD_W-1:0] poly_q,      poly_d;

    // ------------------------------------------------------------------
    // Handshake and datapath nets
    // ------------------------------------------------------------------
    logic               stall;
    logic               advance;
    logic               fire;
    logic [FIELD_W-1:0] red_r;
    logic [FIELD_W-1:0] acc_next;

    // Reduction of the stage-1 product under the current polynomial
    gf16_reduce u_reduce (
        .prod (s1_q.prod),
        .poly (poly_q),
        .r    (red_r)
    );

    // Flow control: a last term may only leave stage 1 when the output
    // register is free or being drained in the same cycle.
    always_comb begin
        stall     = s1_valid_q & s1_q.last & out_valid_q & ~out_ready;
        advance   = s1_valid_q & ~stall;
        in_ready  = ~s1_valid_q | ~stall;
        fire      = in_valid & in_ready;
        acc_next  = (s1_q.first ? '0 : acc_q) ^ red_r;
        busy      = s1_valid_q | mid_frame_q;
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    // Next-state: stage-1 capture, accumulation, output publish, poly load
    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        mid_frame_d = mid_frame_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        poly_d      = poly_q;

        // Stage 1 refills on accept, otherwise empties when its term moves on
        if (fire) begin
            s1_d       = '{prod: in_prod, first: in_first, last: in_last};
            s1_valid_d = 1'b1;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end

        // Downstream consumption frees the output register
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // Stage 2: fold the reduced term into the frame sum. A last term
        // publishes the sum and leaves the accumulator empty, so a following
        // term without in_first still starts from zero.
        if (advance) begin
            if (s1_q.last) begin
                out_data_d  = acc_next;
                out_valid_d = 1'b1;
                acc_d       = '0;
                mid_frame_d = 1'b0;
            end else begin
                acc_d       = acc_next;
                mid_frame_d = 1'b1;
            end
        end

        // Polynomial may change only between frames with nothing in flight;
        // a pending output is unaffected since it is already reduced.
        if (poly_ld && !busy) begin
            poly_d = poly_i;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            mid_frame_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            poly_q      <= POLY_DEFAULT;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            mid_frame_q <= mid_frame_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            poly_q      <= poly_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/gf16_reduce_acc.md
GF16_REDUCE_ACC -- requirements
Module: gf16_reduce_acc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: in_prod, in_first and in_last are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts a term this cycle.
REQ-005 SHALL have port in_prod, input, 31 bits: unreduced GF(2)[x] product of two 16-bit polynomials; bit i is the coefficient of x^i.
REQ-006 SHALL have port in_first, input, 1 bit: term starts a new frame.
REQ-007 SHALL have port in_last, input, 1 bit: term ends the frame.
REQ-008 SHALL have port poly_i, input, 16 bits: low coefficients of the reduction polynomial; the x^16 term is implicit.
REQ-009 SHALL have port poly_ld, input, 1 bit: request to load poly_i.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a completed frame result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes out_data.
REQ-012 SHALL have port out_data, output, 16 bits: XOR-sum of the reduced terms of a frame.
REQ-013 SHALL have port busy, output, 1 bit: a term is in flight, or the accumulator is non-empty mid-frame.

Function
REQ-014 SHALL accept a term on fire, where fire = in_valid & in_ready.
REQ-015 SHALL implement stage 1 as a register that captures in_prod, in_first and in_last on fire (s1_valid).
REQ-016 SHALL implement stage 2 as follows: r = s1_prod mod (x^16 + poly), computed combinationally; then acc <= (s1_first ? 0 : acc) ^ r.
REQ-017 SHALL, when a stage-2 term has s1_last set, load out_data with the final acc value, set out_valid and clear acc to 0.
REQ-018 SHALL have a latency of 2 cycles: a last term accepted at edge t gives out_valid=1 after edge t+1.
REQ-019 SHALL sustain a throughput of one term per cycle while not back-pressured.
REQ-020 SHALL stall stage 1 when s1_last=1 and out_valid=1 and out_ready=0.
REQ-021 SHALL drive in_ready = !s1_valid | !stall.
REQ-022 SHALL hold out_valid and out_data stable until out_ready=1.
REQ-023 SHALL, when out_ready and a new last term arrive in the same cycle, consume the old result and load the new one, keeping out_valid=1.
REQ-024 SHALL treat in_first and in_last both set as a single-term frame.
REQ-025 SHALL start a term arriving after a completed frame without in_first from acc=0.
REQ-026 SHALL accept poly_ld only when busy=0; a request while busy=1 is ignored with no effect.
REQ-027 SHALL not depend on out_valid for a poly load (a pending output does not block it).
REQ-028 SHALL produce out_data that is a pure function of the frame terms and the polynomial register; no X propagation is allowed with valid inputs.

Reset
REQ-029 SHALL, on rst_n=0, immediately clear s1_valid, out_valid, acc, out_data and busy.
REQ-030 SHALL, on rst_n=0, set the polynomial register to 16'h002D (x^16+x^5+x^3+x^2+1).
REQ-031 SHALL drive in_ready=1 from the first edge after reset deassertion.
REQ-032 SHALL discard any partial frame when reset asserts mid-frame; no output is produced for it.

Structure
REQ-033 SHALL take the following from the shared GF package: POLY_DEFAULT=16'h002D, FIELD_W=16, PROD_W=31.
REQ-034 SHALL place the reduction in one combinational sub-module, gf16_reduce (prod[30:0], poly[15:0] -> r[15:0]), reused by the other field stages.
REQ-035 SHALL contain registers only in gf16_reduce_acc.

Verification
REQ-036 SHALL verify a single-term frame: in_prod=31'h0001_0000, default poly -> out_data=16'h002D, with out_valid exactly 2 cycles after accept.
REQ-037 SHALL verify a back-to-back frame: 31'h1, 31'h2, 31'h4 on consecutive cycles, first on term 1 and last on term 3 -> out_data=16'h0007; this is followed by a single term 31'h0001_0001 -> 16'h002C.
REQ-038 SHALL verify backpressure: out_ready=0 while 2 single-term frames are sent -> in_ready=0 after the second is in stage 1; results come out in order once out_ready=1, with none lost or duplicated.
REQ-039 SHALL verify the polynomial load: poly_ld with poly_i=16'h100B while busy=1 is ignored (x^16 still gives 16'h002D); after idle, a reload then gives x^16 -> 16'h100B.
REQ-040 SHALL verify reset mid-frame: rst_n pulsed low after 2 of 3 terms -> out_valid=0; the next single-term frame 31'h5 gives 16'h0005.
